// File: rtl/munch_pkg.sv
// ============================================================
// munch_pkg -- shared mode encodings and index-width helper. Rev 1.0
// ============================================================
`default_nettype none

package munch_pkg;

  typedef enum logic [1:0] {
    MODE_XOR = 2'd0,
    MODE_AND = 2'd1,
    MODE_ADD = 2'd2,
    MODE_BAD = 2'd3
  } mode_e;

  // Index space is four times the panel edge so trails can run off-panel.
  function automatic int idx_bits(input int coord_bits);
    return coord_bits + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/munch_trail.sv
// ============================================================
// munch_trail -- one colour channel: idx register, tap compare, byte packing. Rev 1.0
// ============================================================
`default_nettype none

module munch_trail #(
  parameter int FRAME_BITS = 12,
  parameter int IDX_BITS   = 8,
  parameter int TRAIL_LEN  = 8,
  parameter int SHIFT      = 0,
  parameter int STEP       = 1,
  parameter int REVERSE    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] frame_i,
  input  logic [IDX_BITS-1:0]   key_i,
  output logic [7:0]            byte_o
);

  localparam int HI_SHIFT = SHIFT + FRAME_BITS - 4;

  logic [IDX_BITS-1:0] idx_d;
  logic [IDX_BITS-1:0] idx_q;

  assign idx_d = IDX_BITS'(frame_i >> SHIFT) - IDX_BITS'(frame_i >> HI_SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_tap
    localparam int POS = (REVERSE != 0) ? k : 7 - k;
    if (k < TRAIL_LEN) begin : g_on
      localparam logic [IDX_BITS-1:0] OFF = IDX_BITS'(k * STEP);
      assign byte_o[POS] = (key_i == (idx_q - OFF));
    end else begin : g_off
      assign byte_o[POS] = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/munch_painter.sv
// ============================================================
// munch_painter -- two-stage trail-pattern pixel painter; optional MUNCH_WINDOW_EN overlay. Rev 1.0
// ============================================================
`default_nettype none

module munch_painter
  import munch_pkg::*;
#(
  parameter int COORD_BITS = 6,
  parameter int FRAME_BITS = 12,
  parameter int TRAIL_LEN  = 8,
  parameter int R_SHIFT    = 2,
  parameter int G_SHIFT    = 1,
  parameter int B_SHIFT    = 0,
  parameter int R_STEP     = 1,
  parameter int G_STEP     = 2,
  parameter int B_STEP     = 4,
  parameter int G_REVERSE  = 1,
  parameter int AUTO_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic [7:0]            subframe,
  input  logic [COORD_BITS-1:0] x,
  input  logic [COORD_BITS-1:0] y,
  input  logic                  mode_adv,
  output logic [1:0]            mode,
  output logic [23:0]           rgb24
);

  localparam int IDX_BITS = idx_bits(COORD_BITS);

  mode_e                 mode_q;
  logic                  msb_q;
  logic                  w_wrap;
  logic                  w_adv;
  logic [COORD_BITS-1:0] key_c;
  logic [IDX_BITS-1:0]   key_d;
  logic [IDX_BITS-1:0]   key_q;
  logic                  vld_q;
  logic [23:0]           rgb_d;
  logic [23:0]           rgb_q;
  logic [7:0]            w_red;
  logic [7:0]            w_grn;
  logic [7:0]            w_blu;
  logic                  unused_subframe;

  assign unused_subframe = ^subframe;

  assign w_wrap = msb_q & ~frame[FRAME_BITS-1];
  assign w_adv  = mode_adv | ((AUTO_CYCLE != 0) & w_wrap);

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_XOR;
      msb_q  <= frame[FRAME_BITS-1];
    end else begin
      msb_q <= frame[FRAME_BITS-1];
      case (mode_q)
        MODE_XOR: if (w_adv) mode_q <= MODE_AND;
        MODE_AND: if (w_adv) mode_q <= MODE_ADD;
        MODE_ADD: if (w_adv) mode_q <= MODE_XOR;
        default:  mode_q <= MODE_XOR;
      endcase
    end
  end

  assign mode = mode_q;

  always_comb begin
    key_c = x ^ y;
    case (mode_q)
      MODE_AND: key_c = x & y;
      MODE_ADD: key_c = x + y;
      default:  key_c = x ^ y;
    endcase
  end

  assign key_d = {{(IDX_BITS - COORD_BITS){1'b0}}, key_c};

  munch_trail #(
    .FRAME_BITS(FRAME_BITS), .IDX_BITS(IDX_BITS), .TRAIL_LEN(TRAIL_LEN),
    .SHIFT(R_SHIFT), .STEP(R_STEP), .REVERSE(0)
  ) u_red (
    .clk(clk), .reset(reset), .frame_i(frame), .key_i(key_q), .byte_o(w_red)
  );

  munch_trail #(
    .FRAME_BITS(FRAME_BITS), .IDX_BITS(IDX_BITS), .TRAIL_LEN(TRAIL_LEN),
    .SHIFT(G_SHIFT), .STEP(G_STEP), .REVERSE(G_REVERSE)
  ) u_grn (
    .clk(clk), .reset(reset), .frame_i(frame), .key_i(key_q), .byte_o(w_grn)
  );

  munch_trail #(
    .FRAME_BITS(FRAME_BITS), .IDX_BITS(IDX_BITS), .TRAIL_LEN(TRAIL_LEN),
    .SHIFT(B_SHIFT), .STEP(B_STEP), .REVERSE(0)
  ) u_blu (
    .clk(clk), .reset(reset), .frame_i(frame), .key_i(key_q), .byte_o(w_blu)
  );

`ifdef MUNCH_WINDOW_EN
  logic [COORD_BITS-1:0] w_wx;
  logic [COORD_BITS-1:0] w_wy;
  logic                  win_d;
  logic                  wm_d;
  logic                  win_q;
  logic                  wm_q;

  assign w_wx  = x + frame[0 +: COORD_BITS];
  assign w_wy  = y + frame[2 +: COORD_BITS];
  assign win_d = (w_wx[COORD_BITS-1 -: 2] == 2'b00) && (w_wy[COORD_BITS-1 -: 2] == 2'b00);
  assign wm_d  = ((w_wx ^ COORD_BITS'(frame[3 +: 4])) == w_wy);

  always_ff @(posedge clk) begin
    if (reset) begin
      win_q <= 1'b0;
      wm_q  <= 1'b0;
    end else begin
      win_q <= win_d;
      wm_q  <= wm_d;
    end
  end

  always_comb begin
    rgb_d = 24'h0;
    if (vld_q && win_q) begin
      rgb_d = {7'b0, wm_q, 8'h00, 7'b0, wm_q};
    end else if (vld_q) begin
      rgb_d = {w_blu, w_grn, w_red};
    end
  end
`else
  // The valid bit keeps cleared stage-1 state from painting after reset release.
  always_comb begin
    rgb_d = 24'h0;
    if (vld_q) begin
      rgb_d = {w_blu, w_grn, w_red};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q <= '0;
      vld_q <= 1'b0;
      rgb_q <= 24'h0;
    end else begin
      key_q <= key_d;
      vld_q <= 1'b1;
      rgb_q <= rgb_d;
    end
  end

  assign rgb24 = rgb_q;

endmodule

`default_nettype wire

// File: tb/tb_munch_painter.sv
// ============================================================
// tb_munch_painter -- randomized bench with a behavioural reference model. Rev 1.0
// ============================================================
`default_nettype none

module tb_munch_painter;

  logic        clk;
  logic        reset;
  logic [11:0] frame;
  logic [7:0]  subframe;
  logic [5:0]  x;
  logic [5:0]  y;
  logic        mode_adv;
  logic [1:0]  mode;
  logic [23:0] rgb24;

  int tests = 0;
  int fails = 0;

  munch_painter dut (
    .clk(clk), .reset(reset), .frame(frame), .subframe(subframe),
    .x(x), .y(y), .mode_adv(mode_adv), .mode(mode), .rgb24(rgb24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Colour a pixel straight from the trail rules: tap k lights when key == idx - k*step.
  function automatic logic [23:0] colour(input logic [11:0] f, input logic [5:0] px,
                                         input logic [5:0] py, input int md);
    int fi, key, idx, sh, st, pos;
    logic [7:0] ch [3];
    fi = int'(f);
    if (md == 0)      key = int'(px ^ py);
    else if (md == 1) key = int'(px & py);
    else              key = (int'(px) + int'(py)) % 64;
    for (int c = 0; c < 3; c++) begin
      sh = (c == 0) ? 2 : (c == 1) ? 1 : 0;
      st = (c == 0) ? 1 : (c == 1) ? 2 : 4;
      idx = ((fi >> sh) - (fi >> (sh + 8))) & 255;
      ch[c] = 8'h00;
      for (int k = 0; k < 8; k++) begin
        if (((idx - k * st - key) & 255) == 0) begin
          pos = (c == 1) ? k : 7 - k;
          ch[c][pos[2:0]] = 1'b1;
        end
      end
    end
`ifdef MUNCH_WINDOW_EN
    begin
      int wx, wy;
      wx = (int'(px) + int'(f[5:0])) % 64;
      wy = (int'(py) + int'(f[7:2])) % 64;
      if (wx < 16 && wy < 16)
        return ((wx ^ int'(f[6:3])) == wy) ? 24'h010001 : 24'h000000;
    end
`endif
    return {ch[2], ch[1], ch[0]};
  endfunction

  // Reference: two-deep pixel latency, mode advancing on pulse or frame wrap.
  initial begin : model
    logic        r, a, msb, s1v;
    logic [11:0] f;
    logic [5:0]  px, py;
    logic [23:0] s1c, exp_rgb;
    int          mm;
    mm = 0; msb = 1'b0; s1v = 1'b0; s1c = 24'h0; exp_rgb = 24'h0;
    forever begin
      @(posedge clk);
      r = reset; f = frame; px = x; py = y; a = mode_adv;
      if (r) begin
        mm = 0; msb = f[11]; s1v = 1'b0; exp_rgb = 24'h0;
      end else begin
        exp_rgb = s1v ? s1c : 24'h0;
        s1c = colour(f, px, py, mm);
        s1v = 1'b1;
        if (a || (msb && !f[11])) mm = (mm + 1) % 3;
        msb = f[11];
      end
      #1;
      chk("model_rgb", rgb24, exp_rgb);
      chk("model_mode", mode, mm);
    end
  end

  initial begin : stim
    int hold;
    reset = 1'b1; frame = 12'h0; subframe = 8'h0; x = 6'd0; y = 6'd0; mode_adv = 1'b0;

    repeat (3) begin
      @(posedge clk); #2;
      chk("reset_rgb", rgb24, 24'h0);
      chk("reset_mode", mode, 2'd0);
    end
    @(negedge clk); reset = 1'b0; #1;
    chk("release0_rgb", rgb24, 24'h0);
    @(posedge clk); #2;
    chk("release1_rgb", rgb24, 24'h0);
    @(posedge clk); #2;
`ifdef MUNCH_WINDOW_EN
    chk("xor_origin_win", rgb24, 24'h010001);
`else
    chk("xor_origin", rgb24, 24'h800180);
`endif

    @(negedge clk); frame = 12'd16; x = 6'd1; y = 6'd0;
    @(posedge clk); @(posedge clk); #2;
    chk("frame16_red_tap3", rgb24, 24'h000010);

    @(negedge clk); mode_adv = 1'b1;
    @(posedge clk); #2;
    chk("adv_to_and", mode, 2'd1);
    @(negedge clk); mode_adv = 1'b0; frame = 12'h0; x = 6'd3; y = 6'd5;
    @(posedge clk); @(posedge clk); #2;
    chk("and_key1", rgb24, 24'h0);

    @(negedge clk); mode_adv = 1'b1;
    @(negedge clk); mode_adv = 1'b0;
    chk("adv_to_add", mode, 2'd2);
    frame = 12'hFFF;
    @(negedge clk); frame = 12'h000;
    @(negedge clk);
    chk("wrap_to_xor", mode, 2'd0);
    repeat (4) @(negedge clk);
    chk("wrap_once", mode, 2'd0);
    frame = 12'hFFF;
    @(negedge clk); frame = 12'h000; mode_adv = 1'b1;
    @(negedge clk); mode_adv = 1'b0;
    chk("wrap_plus_adv_once", mode, 2'd1);

`ifdef MUNCH_WINDOW_EN
    @(negedge clk); frame = 12'h0; x = 6'd0; y = 6'd0;
    @(posedge clk); @(posedge clk); #2;
    chk("window_on", rgb24, 24'h010001);
    @(negedge clk); x = 6'd40;
    @(posedge clk); @(posedge clk); #2;
    chk("window_off_x40", rgb24, 24'h800180);
`endif

    @(negedge clk); frame = 12'h5A3; reset = 1'b1;
    @(posedge clk); #2;
    chk("midframe_reset_rgb", rgb24, 24'h0);
    chk("midframe_reset_mode", mode, 2'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #2;
    chk("midframe_release_rgb", rgb24, 24'h0);

    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (hold == 0) begin
        case ($urandom_range(0, 3))
          0: frame = 12'($urandom);
          1: frame = frame + 12'd1;
          2: frame = 12'hFFF;
          default: frame = 12'h000;
        endcase
        hold = $urandom_range(1, 8);
      end
      hold--;
      x = 6'($urandom);
      y = 6'($urandom);
      subframe = 8'($urandom);
      mode_adv = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 149) == 0);
    end

    @(negedge clk); reset = 1'b0; mode_adv = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/munch_painter.md
MUNCH_PAINTER -- requirements
Module: munch_painter

Interface
REQ-001 SHALL have parameter COORD_BITS, default 6: width of x/y; the panel is 2^COORD_BITS square.
REQ-002 SHALL have parameter FRAME_BITS, default 12: width of frame; minimum 8.
REQ-003 SHALL have parameter TRAIL_LEN, default 8: trail taps per channel; legal range 1..8.
REQ-004 SHALL have parameters R_SHIFT=2, G_SHIFT=1, B_SHIFT=0: per-channel frame speed divisors.
REQ-005 SHALL have parameters R_STEP=1, G_STEP=2, B_STEP=4: per-channel spacing between trail taps.
REQ-006 SHALL have parameter G_REVERSE, default 1: 1 maps the green trail LSB-first.
REQ-007 SHALL have parameter AUTO_CYCLE, default 1: 1 makes a frame-counter wrap advance the mode.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port frame, input, FRAME_BITS: frame counter; held stable for many cycles.
REQ-011 SHALL have port subframe, input, 8 bits: reserved; ignored.
REQ-012 SHALL have ports x and y, input, COORD_BITS each: the pixel address, one pixel per cycle.
REQ-013 SHALL have port mode_adv, input, 1 bit: single-cycle pulse that advances the mode.
REQ-014 SHALL have port mode, output, 2 bits: current mode (0=XOR, 1=AND, 2=ADD).
REQ-015 SHALL have port rgb24, output, 24 bits, packed {blu,grn,red}.

Function
REQ-016 SHALL define IDX_BITS = COORD_BITS+2; all index arithmetic is modulo 2^IDX_BITS.
REQ-017 SHALL register, every cycle, idx_c = (frame>>c_SHIFT) - (frame>>(c_SHIFT+FRAME_BITS-4)) for each channel c.
REQ-018 SHALL form the stage-1 key from the current mode: XOR = x^y, AND = x&y, ADD = (x+y) mod 2^COORD_BITS.
REQ-019 SHALL register the stage-1 key, zero-extended to IDX_BITS.
REQ-020 SHALL, in stage 2, set tap k (0..TRAIL_LEN-1) of channel c when key == idx_c - k*c_STEP.
REQ-021 SHALL place tap k at byte bit 7-k (bit k for green when G_REVERSE=1); bits for k>=TRAIL_LEN SHALL be 0.
REQ-022 SHALL register rgb24; latency from x/y to rgb24 is exactly 2 cycles, fully pipelined.
REQ-023 SHALL treat mode as a 3-state machine XOR->AND->ADD->XOR; state value 3 is unreachable and SHALL recover to XOR.
REQ-024 SHALL define a wrap event as the registered frame MSB being 1 while the current frame MSB is 0.
REQ-025 SHALL advance mode once on mode_adv, or on a wrap event when AUTO_CYCLE=1; simultaneous events SHALL advance it once.
REQ-026 SHALL apply a mode change to pixels entering stage 1 on the cycle after the change.

Reset
REQ-027 SHALL, on reset, clear every idx, key, pipeline and colour register and set mode=XOR and rgb24=0.
REQ-028 SHALL hold rgb24 at 0 through reset and for 2 cycles after release; this holds for reset asserted mid-frame too.
REQ-029 SHALL, on reset, load the registered frame MSB from the current frame so that release raises no false wrap.

Configuration
REQ-030 SHALL, with MUNCH_WINDOW_EN defined, compute wx = x+frame[0+:COORD_BITS] and wy = y+frame[2+:COORD_BITS].
REQ-031 SHALL, with MUNCH_WINDOW_EN defined, flag in_window when the top 2 bits of both wx and wy are 0, pipelined alongside the key.
REQ-032 SHALL, with MUNCH_WINDOW_EN defined, override rgb24 inside the window with {wm,8'h00,wm}, where wm = 8'h01 if (wx ^ frame[3+:4]) == wy, else 8'h00.
REQ-033 SHALL, without MUNCH_WINDOW_EN, contain no window logic, and rgb24 is the trail colour only.

Structure
REQ-034 SHALL keep the mode encodings (MODE_XOR/AND/ADD) and the IDX_BITS derivation in a shared package, munch_pkg.
REQ-035 SHALL implement one channel (idx register, tap compare, byte packing) as sub-module munch_trail, instantiated three times.

Verification (COORD_BITS=6, FRAME_BITS=12, defaults)
REQ-036 SHALL check: reset held 3 cycles -> rgb24=0 and mode=0 during reset and for 2 cycles after release.
REQ-037 SHALL check, without the macro: frame=0, x=0, y=0, XOR -> rgb24=24'h800180 two cycles after the pixel.
REQ-038 SHALL check, without the macro: frame=16, x=1, y=0 -> idx r/g/b=4/8/16; red tap 3 is set, so rgb24=24'h000010.
REQ-039 SHALL check: one-cycle mode_adv -> mode 0->1; then x=3, y=5 with frame=0 -> key 1 and rgb24=24'h000000.
REQ-040 SHALL check: frame 12'hFFF->12'h000 with mode=2 -> mode=0 exactly once; the same wrap with a coincident mode_adv still advances once.
REQ-041 SHALL check, with MUNCH_WINDOW_EN: frame=0, x=0, y=0 -> rgb24=24'h010001; x=40 -> the window override is off.
